// File: rtl/vjtag_uart_pkg.sv
// Shared types and constants for the VirtualJTAG UART FIFO bridge.
package vjtag_uart_pkg;

  typedef logic [7:0] byte_t;

  // Host read command sequencer states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHdr  = 2'd1,
    StHdr2 = 2'd2,
    StData = 2'd3
  } rd_state_e;

  localparam byte_t FillByteDefault = 8'h00;

  // Clamp a count to a limit and return it as a byte (limit is always <= 255)
  function automatic byte_t sat_byte(input int unsigned value, input int unsigned limit);
    return (value > limit) ? byte_t'(limit) : byte_t'(value);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and full/empty/count flags.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     m_clock,
  input  logic                     p_reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers and occupancy
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty so it needs no reset
  always_ff @(posedge m_clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vjtag_uart_fifo.sv
// User-side peer of the VirtualJTAG byte channel. RX FIFO buffers host->FPGA bytes,
// TX FIFO buffers FPGA->host bytes; every host read is framed with a count header.
// Optional VJTAG_UART_FIFO_STATUS_EN: adds an RX free-space header byte and lets
// recv_init clear rx_overflow.
module vjtag_uart_fifo
  import vjtag_uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter byte_t       FILL_BYTE = FillByteDefault,
  parameter int unsigned HDR_MAX   = 255
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic       recv_init,
  input  logic       recv,
  input  logic [7:0] recv_data,
  input  logic       send_init,
  input  logic       send_ready,
  output logic       send,
  output logic [7:0] send_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       rx_overflow
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  // RX path
  logic          rx_pop, rx_full, rx_empty;
  logic [CW-1:0] rx_count;

  assign rx_pop   = rx_valid && rx_ready;
  assign rx_valid = !rx_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .m_clock   (m_clock),
    .p_reset   (p_reset),
    .push      (recv),
    .push_data (recv_data),
    .pop       (rx_pop),
    .head      (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // TX path
  logic          tx_push, tx_pop, tx_full, unused_tx_empty;
  logic [CW-1:0] tx_count;
  byte_t         tx_head;

  assign tx_ready = !tx_full;
  assign tx_push  = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .m_clock   (m_clock),
    .p_reset   (p_reset),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (unused_tx_empty),
    .count     (tx_count)
  );

  // Read command sequencer
  rd_state_e state_q, state_d, cur_state;
  byte_t     remaining_q, remaining_d, cur_remaining, snap_remaining;
  byte_t     load_data, send_data_q;
  logic      send_q, rx_overflow_q;

  assign snap_remaining = sat_byte(32'(tx_count), HDR_MAX);
  // send_init takes effect before a coincident send_ready, which then acts on HDR
  assign cur_state      = send_init ? StHdr : state_q;
  assign cur_remaining  = send_init ? snap_remaining : remaining_q;

`ifdef VJTAG_UART_FIFO_STATUS_EN
  byte_t rx_free_q, rx_free_d, cur_rx_free, snap_rx_free;

  assign snap_rx_free = sat_byte(DEPTH - 32'(rx_count), 255);
  assign cur_rx_free  = send_init ? snap_rx_free : rx_free_q;
`else
  logic unused_status;
  assign unused_status = ^{rx_count, recv_init};
`endif

  // State, remaining count and snapshot registers
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
`ifdef VJTAG_UART_FIFO_STATUS_EN
      rx_free_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
`ifdef VJTAG_UART_FIFO_STATUS_EN
      rx_free_q   <= rx_free_d;
`endif
    end
  end

  // Next-state: snapshot on send_init, advance on send_ready
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
`ifdef VJTAG_UART_FIFO_STATUS_EN
    rx_free_d   = rx_free_q;
`endif
    if (send_init) begin
      state_d     = StHdr;
      remaining_d = snap_remaining;
`ifdef VJTAG_UART_FIFO_STATUS_EN
      rx_free_d   = snap_rx_free;
`endif
    end
    if (send_ready) begin
      unique case (cur_state)
        StIdle: ;
`ifdef VJTAG_UART_FIFO_STATUS_EN
        StHdr:  state_d = StHdr2;
`else
        StHdr:  state_d = StData;
`endif
        StHdr2: state_d = StData;
        StData: if (cur_remaining != '0) remaining_d = cur_remaining - 8'd1;
        default: ;
      endcase
    end
  end

  // Output decode: byte to load and TX pop for this send_ready
  always_comb begin
    load_data = FILL_BYTE;
    tx_pop    = 1'b0;
    unique case (cur_state)
      StIdle: ;
      StHdr:  load_data = cur_remaining;
`ifdef VJTAG_UART_FIFO_STATUS_EN
      StHdr2: load_data = cur_rx_free;
`else
      StHdr2: ;
`endif
      StData: begin
        if (cur_remaining != '0) begin
          load_data = tx_head;
          tx_pop    = send_ready;
        end
      end
      default: ;
    endcase
  end

  // Registered load strobe: one cycle after send_ready
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      send_q      <= 1'b0;
      send_data_q <= '0;
    end else begin
      send_q <= send_ready;
      if (send_ready) send_data_q <= load_data;
    end
  end

  // Sticky overflow: a received byte found RX full with no pop to make room
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      rx_overflow_q <= 1'b0;
    end else if (recv && rx_full && !rx_pop) begin
      rx_overflow_q <= 1'b1;
`ifdef VJTAG_UART_FIFO_STATUS_EN
    end else if (recv_init) begin
      rx_overflow_q <= 1'b0;
`endif
    end
  end

  assign send        = send_q;
  assign send_data   = send_data_q;
  assign rx_overflow = rx_overflow_q;

endmodule

// File: tb/tb_vjtag_uart_fifo.sv
// Self-checking bench for vjtag_uart_fifo: directed scenarios plus random traffic,
// all checked against a queue-based model of the byte channel protocol.
module tb_vjtag_uart_fifo;

  localparam int unsigned DEPTH   = 16;
  localparam logic [7:0]  FILL    = 8'hC3;
  localparam int unsigned HDR_MAX = 12;

  logic       m_clock = 1'b0;
  logic       p_reset, recv_init, recv, send_init, send_ready, rx_ready, tx_valid;
  logic [7:0] recv_data, tx_data;
  logic       send, rx_valid, tx_ready, rx_overflow;
  logic [7:0] send_data, rx_data;

  vjtag_uart_fifo #(
    .DEPTH     (DEPTH),
    .FILL_BYTE (FILL),
    .HDR_MAX   (HDR_MAX)
  ) dut (
    .m_clock     (m_clock),
    .p_reset     (p_reset),
    .recv_init   (recv_init),
    .recv        (recv),
    .recv_data   (recv_data),
    .send_init   (send_init),
    .send_ready  (send_ready),
    .send        (send),
    .send_data   (send_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_overflow (rx_overflow)
  );

  always #5 m_clock = ~m_clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: FIFO contents as queues; a host command is the list of bytes it will read
  logic [7:0] m_rx[$];
  logic [7:0] m_tx[$];
  logic [7:0] m_seq[$];
  logic [7:0] loads[$];
  int         m_hdr_left = 0;
  bit         m_ovf = 0, m_send = 0, m_valid = 0;
  logic [7:0] m_send_data = 8'h00;

  task automatic check_outputs();
    if (!m_valid) return;
    check_eq("send", 32'(send), 32'(m_send));
    if (m_send) begin
      check_eq("send_data", 32'(send_data), 32'(m_send_data));
      loads.push_back(send_data);
    end
    check_eq("rx_valid", 32'(rx_valid), 32'(m_rx.size() != 0));
    if (m_rx.size() != 0) check_eq("rx_data", 32'(rx_data), 32'(m_rx[0]));
    check_eq("tx_ready", 32'(tx_ready), 32'(m_tx.size() < DEPTH));
    check_eq("rx_overflow", 32'(rx_overflow), 32'(m_ovf));
  endtask

  task automatic model_update();
    int n;
    int f;
    bit rx_pop, rx_full_pre, tx_full_pre;
    if (p_reset) begin
      m_rx.delete();
      m_tx.delete();
      m_seq.delete();
      m_hdr_left  = 0;
      m_ovf       = 0;
      m_send      = 0;
      m_send_data = 8'h00;
      m_valid     = 1;
      return;
    end
    rx_full_pre = (m_rx.size() >= DEPTH);
    tx_full_pre = (m_tx.size() >= DEPTH);
    if (send_init) begin
      n = (m_tx.size() > HDR_MAX) ? HDR_MAX : m_tx.size();
      m_seq.delete();
      m_seq.push_back(8'(n));
      m_hdr_left = 1;
`ifdef VJTAG_UART_FIFO_STATUS_EN
      f = DEPTH - m_rx.size();
      if (f > 255) f = 255;
      m_seq.push_back(8'(f));
      m_hdr_left = 2;
`endif
      for (int i = 0; i < n; i++) m_seq.push_back(m_tx[i]);
    end
    m_send = send_ready;
    if (send_ready) begin
      if (m_seq.size() == 0) begin
        m_send_data = FILL;
      end else begin
        m_send_data = m_seq.pop_front();
        if (m_hdr_left > 0) m_hdr_left--;
        else void'(m_tx.pop_front());
      end
    end
    if (tx_valid && !tx_full_pre) m_tx.push_back(tx_data);
    rx_pop = rx_ready && (m_rx.size() != 0);
    if (rx_pop) void'(m_rx.pop_front());
`ifdef VJTAG_UART_FIFO_STATUS_EN
    if (recv_init) m_ovf = 0;
`endif
    if (recv) begin
      if (!rx_full_pre || rx_pop) m_rx.push_back(recv_data);
      else m_ovf = 1;
    end
  endtask

  task automatic cycle();
    check_outputs();
    model_update();
    @(posedge m_clock);
    @(negedge m_clock);
  endtask

  task automatic idle_inputs();
    p_reset    = 1'b0;
    recv_init  = 1'b0;
    recv       = 1'b0;
    send_init  = 1'b0;
    send_ready = 1'b0;
    tx_valid   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    p_reset = 1'b1;
    cycle();
    cycle();
    idle_inputs();
    cycle();
    check_eq("rst_send_data", 32'(send_data), 32'h0);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'h1);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'h0);
    loads.delete();
  endtask

  task automatic push_tx(input logic [7:0] b);
    idle_inputs();
    tx_valid = 1'b1;
    tx_data  = b;
    cycle();
    idle_inputs();
  endtask

  task automatic recv_byte(input logic [7:0] b);
    idle_inputs();
    recv      = 1'b1;
    recv_data = b;
    cycle();
    idle_inputs();
  endtask

  task automatic sinit();
    idle_inputs();
    send_init = 1'b1;
    cycle();
    idle_inputs();
    cycle();
  endtask

  // send_ready pulse with channel-like spacing between pulses
  task automatic sready();
    idle_inputs();
    send_ready = 1'b1;
    cycle();
    idle_inputs();
    repeat (3) cycle();
  endtask

  task automatic check_loads(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_len"}, 32'(loads.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < loads.size(); i++)
      check_eq(tag, 32'(loads[i]), 32'(exp[i]));
    loads.delete();
  endtask

  initial begin
    logic [7:0] exp_q[$];
    idle_inputs();
    rx_ready  = 1'b0;
    recv_data = 8'h00;
    tx_data   = 8'h00;
    do_reset();

    // 1: three TX bytes, header then data then fill
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    sinit();
    repeat (5) sready();
    exp_q = {8'h03, 8'h11, 8'h22, 8'h33, FILL};
    check_loads("t1_loads", exp_q);

    // 2: RX pass-through with rx_ready held
    rx_ready = 1'b1;
    recv_byte(8'hA5);
    recv_byte(8'h5A);
    repeat (3) cycle();
    check_eq("t2_ovf", 32'(rx_overflow), 32'h0);

    // 3: RX overflow, last byte dropped
    rx_ready = 1'b0;
    do_reset();
    for (int i = 0; i <= DEPTH; i++) recv_byte(8'(i + 1));
    cycle();
    check_eq("t3_ovf", 32'(rx_overflow), 32'h1);
    check_eq("t3_head", 32'(rx_data), 32'h1);
    rx_ready = 1'b1;
    repeat (DEPTH + 2) cycle();
    check_eq("t3_drained", 32'(rx_valid), 32'h0);
    rx_ready = 1'b0;

    // 4: empty TX, then one byte
    do_reset();
    sinit();
    repeat (3) sready();
    exp_q = {8'h00, FILL, FILL};
    check_loads("t4a_loads", exp_q);
    push_tx(8'h7E);
    sinit();
    repeat (2) sready();
    exp_q = {8'h01, 8'h7E};
    check_loads("t4b_loads", exp_q);

    // 5: send_init mid-command discards the remaining count
    do_reset();
    for (int i = 0; i < 4; i++) push_tx(8'hB0 + 8'(i));
    sinit();
    repeat (2) sready();
    sinit();
    repeat (4) sready();
    exp_q = {8'h04, 8'hB0, 8'h03, 8'hB1, 8'hB2, 8'hB3};
    check_loads("t5_loads", exp_q);

    // Header saturation and coincident send_init/send_ready
    do_reset();
    for (int i = 0; i < 14; i++) push_tx(8'h40 + 8'(i));
    check_eq("full_minus2_ready", 32'(tx_ready), 32'h1);
    idle_inputs();
    send_init  = 1'b1;
    send_ready = 1'b1;
    cycle();
    idle_inputs();
    repeat (3) cycle();
    sready();
    exp_q = {8'(HDR_MAX), 8'h40};
    check_loads("sat_loads", exp_q);
    for (int i = 0; i < 8; i++) push_tx(8'h90 + 8'(i));
    check_eq("tx_full", 32'(tx_ready), 32'h0);
    loads.delete();

`ifdef VJTAG_UART_FIFO_STATUS_EN
    // 6: status header reports RX free space
    do_reset();
    recv_byte(8'h01);
    recv_byte(8'h02);
    push_tx(8'hE7);
    sinit();
    repeat (3) sready();
    exp_q = {8'h01, 8'h0E, 8'hE7};
    check_loads("t6_loads", exp_q);
`endif

    // Reset in the middle of a command
    do_reset();
    push_tx(8'h12);
    push_tx(8'h34);
    sinit();
    sready();
    idle_inputs();
    send_ready = 1'b1;
    p_reset    = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    check_eq("mid_rst_send", 32'(send), 32'h0);
    check_eq("mid_rst_tx_ready", 32'(tx_ready), 32'h1);
    loads.delete();

    // Random traffic in three phases: TX filling, balanced, RX congested
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      recv       = ($urandom_range(0, 2) == 0);
      recv_data  = 8'($urandom);
      recv_init  = ($urandom_range(0, 15) == 0);
      rx_ready   = (c >= 2000) ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      tx_valid   = (c < 1000) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 5) == 0);
      tx_data    = 8'($urandom);
      send_init  = ($urandom_range(0, 24) == 0);
      send_ready = ($urandom_range(0, 3) == 0);
      p_reset    = ($urandom_range(0, 799) == 0);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
